// File: rtl/nspi_frame_feeder.sv
// nspi_frame_feeder: streams one frame of multi-channel SPI words from memory into nspi_tx.
module nspi_frame_feeder #(
  parameter int CHANNEL_NUMBER  = 2,
  parameter int SPI_SIZE        = 8,
  parameter int BYTES_PER_FRAME = 384,
  parameter int ADDR_W          = 9,
  parameter int GAP_CYCLES      = 64,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] mem_rd_data,
  output logic                               start_tx,
  input  logic                               tx_finish,
  output logic [SPI_SIZE-1:0]                data_out [CHANNEL_NUMBER]
);
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0]     ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]     GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_WAIT_READY, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP
  } state_t;

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_byte_idx;
  logic [TW-1:0]       r_timer;
  logic                r_pending, r_err, r_frame_done;
  logic [SPI_SIZE-1:0] r_data [CHANNEL_NUMBER];
  logic                w_idx_clr, w_idx_inc, w_tmr_clr, w_tmr_inc;
  logic                w_load, w_err_set, w_pend_clr, w_done;

  assign busy        = (r_state != S_IDLE);
  assign mem_rd_en   = (r_state == S_FETCH);
  assign start_tx    = (r_state == S_START);
  assign mem_rd_addr = r_byte_idx;
  assign frame_done  = r_frame_done;
  assign err         = r_err;
  assign data_out    = r_data;

  always_comb begin
    w_state_nx = r_state;
    w_idx_clr  = 1'b0;
    w_idx_inc  = 1'b0;
    w_tmr_clr  = 1'b0;
    w_tmr_inc  = 1'b0;
    w_load     = 1'b0;
    w_err_set  = 1'b0;
    w_pend_clr = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: if (frame_start || r_pending) begin
        w_state_nx = S_FETCH;
        w_idx_clr  = 1'b1;
        w_pend_clr = 1'b1;
      end
      S_FETCH:      w_state_nx = S_CAPTURE;
      S_CAPTURE: begin
        w_state_nx = S_WAIT_READY;
        w_load     = 1'b1;
      end
      S_WAIT_READY: w_state_nx = tx_finish ? S_START : S_WAIT_READY;
      S_START: begin
        w_state_nx = S_WAIT_ACK;
        w_tmr_clr  = 1'b1;
      end
      S_WAIT_ACK: begin
        if (!tx_finish) w_state_nx = S_WAIT_DONE;
        else if (r_timer == ACK_LAST) begin
          w_state_nx = S_IDLE;
          w_err_set  = 1'b1;
          w_pend_clr = 1'b1;
        end else w_tmr_inc = 1'b1;
      end
      S_WAIT_DONE: if (tx_finish) begin
        if (r_byte_idx == LAST_IDX) begin
          w_tmr_clr = 1'b1;
          // a zero-length gap finishes straight from here
          if (GAP_CYCLES == 0) begin
            w_state_nx = S_IDLE;
            w_done     = 1'b1;
          end else w_state_nx = S_GAP;
        end else begin
          w_idx_inc  = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end else w_tmr_inc = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_byte_idx   <= '0;
      r_timer      <= '0;
      r_pending    <= 1'b0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      r_data       <= '{default: '0};
    end else begin
      r_state      <= w_state_nx;
      r_frame_done <= w_done;
      if (w_err_set) r_err <= 1'b1;
      r_pending    <= w_pend_clr ? 1'b0 : (r_pending | (frame_start & busy));
      r_byte_idx   <= w_idx_clr ? '0 : w_idx_inc ? r_byte_idx + 1'b1 : r_byte_idx;
      r_timer      <= w_tmr_clr ? '0 : w_tmr_inc ? r_timer + 1'b1 : r_timer;
      if (w_load)
        for (int c = 0; c < CHANNEL_NUMBER; c++) r_data[c] <= mem_rd_data[c*SPI_SIZE +: SPI_SIZE];
    end
  end
endmodule

// File: doc/nspi_frame_feeder.md
NSPI_FRAME_FEEDER -- requirements
Module: nspi_frame_feeder

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- CHANNEL_NUMBER, 2, parallel SPI channels.
- SPI_SIZE, 8, bits per SPI word.
- BYTES_PER_FRAME, 384, words per channel per frame.
- ADDR_W, 9, memory address width; must satisfy 2^ADDR_W >= BYTES_PER_FRAME.
- GAP_CYCLES, 64, idle cycles after the last word before frame_done; 0 allowed.
- ACK_TIMEOUT, 8, cycles allowed for tx_finish to fall after start_tx.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- frame_start, in, 1, frame request pulse.
- busy, out, 1, high in any state other than IDLE.
- frame_done, out, 1, one-cycle pulse when a frame completes.
- err, out, 1, sticky acknowledge-timeout flag.
- mem_rd_en, out, 1, frame memory read strobe.
- mem_rd_addr, out, ADDR_W, word index.
- mem_rd_data, in, CHANNEL_NUMBER*SPI_SIZE, memory word valid the cycle after mem_rd_en; channel c at bits [c*SPI_SIZE +: SPI_SIZE].
- start_tx, out, 1, to the downstream nspi_tx.
- tx_finish, in, 1, from nspi_tx; high = transmitter idle.
- data_out, out, CHANNEL_NUMBER x SPI_SIZE unpacked array, connects to nspi_tx data_in.
REQ-003 SHALL use a single clock domain with reset asynchronous and active-low, as fixed above.

Function
REQ-004 SHALL implement states IDLE, FETCH, CAPTURE, WAIT_READY, START, WAIT_ACK, WAIT_DONE, GAP; all outputs SHALL be registered or decoded from registered state.
REQ-005 IDLE: if frame_start=1 or pending=1, then byte_idx<=0, pending<=0, next state FETCH.
REQ-006 FETCH: mem_rd_en=1 and mem_rd_addr=byte_idx for exactly one cycle, then CAPTURE.
REQ-007 CAPTURE: data_out[c] <= mem_rd_data[c*SPI_SIZE +: SPI_SIZE] for every c, then WAIT_READY.
REQ-008 WAIT_READY: stay until tx_finish=1, then START.
REQ-009 START: start_tx=1 for exactly one cycle, clear the ack timer, then WAIT_ACK.
REQ-010 WAIT_ACK: on tx_finish=0, go to WAIT_DONE. Otherwise increment the timer; when it reaches ACK_TIMEOUT-1, set err<=1, clear pending, go to IDLE, and do not pulse frame_done.
REQ-011 WAIT_DONE: stay until tx_finish=1. Then, if byte_idx=BYTES_PER_FRAME-1, go to GAP; else byte_idx<=byte_idx+1 and go to FETCH.
REQ-012 GAP: count GAP_CYCLES cycles, then pulse frame_done for one cycle and go to IDLE. With GAP_CYCLES=0, frame_done SHALL pulse in the cycle after the last tx_finish rise is sampled.
REQ-013 data_out SHALL remain stable from the CAPTURE load until the next CAPTURE; it SHALL never change while nspi_tx is transmitting.
REQ-014 Latency: with frame_start sampled at edge k and tx_finish=1:
- mem_rd_en is high during cycle k..k+1.
- data_out is updated at edge k+2.
- start_tx is high during cycle k+3..k+4.
REQ-015 A frame_start seen while busy=1 SHALL set pending (one-deep; further requests are dropped). The pending frame SHALL start from IDLE one cycle after frame_done.
REQ-016 A frame_start coincident with the frame_done cycle SHALL set pending and SHALL NOT be lost.
REQ-017 byte_idx SHALL be ADDR_W wide, SHALL never exceed BYTES_PER_FRAME-1, and SHALL reset to 0 at each frame start (no wrap within a frame).
REQ-018 err SHALL clear only on reset; a set err SHALL NOT block subsequent frames.
REQ-019 start_tx SHALL never be asserted while tx_finish=0 was sampled in the same cycle's state decision (only from WAIT_READY).

Reset
REQ-020 While rst=0, all of the following SHALL hold immediately, independent of clk:
- State is IDLE.
- busy, frame_done, err, mem_rd_en and start_tx are 0.
- mem_rd_addr, byte_idx, all data_out words, pending and the timers are 0.
REQ-021 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse; start_tx SHALL fall asynchronously.

Verification
Bench parameters: CHANNEL_NUMBER=2, SPI_SIZE=8, BYTES_PER_FRAME=4, GAP_CYCLES=3, ACK_TIMEOUT=8. The memory model returns {8'hA0+n, 8'h10+n} at address n, one-cycle latency. The bench includes a nspi_tx behavioural model.
REQ-022 Single frame: pulse frame_start -> exactly 4 start_tx pulses with data_out = (0x10,0xA0), (0x11,0xA1), (0x12,0xA2), (0x13,0xA3). frame_done pulses once, 3 cycles after the 4th tx_finish rise is sampled.
REQ-023 Latency: tx_finish held 1, frame_start at edge k -> mem_rd_addr=0 during k..k+1, data_out valid after k+2, start_tx high during k+3..k+4.
REQ-024 Queued request: frame_start pulsed twice during frame 1 -> exactly two frames (8 start_tx pulses), with frame 2 starting one cycle after the first frame_done. A frame_start coincident with frame_done also yields a second frame.
REQ-025 Timeout: the model never drops tx_finish -> err=1 after 8 cycles in WAIT_ACK, busy=0, no frame_done; the next frame_start then completes normally with err still 1.
REQ-026 Backpressure: tx_finish held 0 for 20 cycles before the first word -> start_tx is withheld until tx_finish=1, and data_out does not change meanwhile.
REQ-027 Reset mid-frame: rst=0 during the 2nd word -> all outputs 0 at once. After release, a new frame_start restarts from address 0.
